pe_col_sched: RTL and testbench

- Sequences one column of NUM_PE row-stationary PEs through a multi-pass 1-D convolution job.
- For each pass it:
  - requests operand loading,
  - fires all PEs with a one-cycle enable,
  - collects their DONE flags,
  - steps the vertical psum reduction across rows,
  - hands the column result downstream on a valid/ready handshake.
- Sits between the global buffer/operand fetch logic and the PE column.

---
 rtl/pe_col_sched.sv | 155 +++++++++++++++
 tb/tb_pe_col_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_col_sched.sv
// Pass sequencer for one column of row-stationary PEs: load, fire, collect
// DONE flags, step the vertical psum reduction, then hand the result downstream.

module pe_col_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cap,
  input  logic pe_done,
  output logic mask
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     mask <= 1'b0;
    else if (clr) mask <= 1'b0;
    else if (cap) mask <= mask | pe_done;
  end
endmodule

module pe_col_sched #(
  parameter int NUM_PE  = 3,
  parameter int PASS_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] num_pass,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              load_req,
  input  logic              load_ack,
  output logic [PASS_W-1:0] pass_idx,
  output logic [NUM_PE-1:0] pe_en,
  input  logic [NUM_PE-1:0] pe_done,
  output logic [2:0]        red_sel,
  output logic              red_en,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0]    LAST_SEL = 3'(NUM_PE - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_REDUCE, S_OUT} state_t;

  state_t              state;
  logic [PASS_W-1:0]   num_pass_q;
  logic [TW-1:0]       tcnt;
  logic [NUM_PE-1:0]   done_mask;
  logic                all_done;
  logic                last_pass;

  // Mask is cleared while the PEs fire so a stale pulse in that cycle never counts.
  for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
    pe_col_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .clr     (state == S_FIRE),
      .cap     (state == S_WAIT),
      .pe_done (pe_done[i]),
      .mask    (done_mask[i])
    );
  end

  assign all_done  = &(done_mask | pe_done);
  assign last_pass = (pass_idx == num_pass_q - PASS_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      num_pass_q <= '0;
      tcnt       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_req   <= 1'b0;
      pass_idx   <= '0;
      pe_en      <= '0;
      red_sel    <= '0;
      red_en     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      done  <= 1'b0;
      pe_en <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_pass != '0) begin
              num_pass_q <= num_pass;
              pass_idx   <= '0;
              err        <= 1'b0;
              busy       <= 1'b1;
              load_req   <= 1'b1;
              state      <= S_LOAD;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (load_ack) begin
            load_req <= 1'b0;
            pe_en    <= '1;
            state    <= S_FIRE;
          end
        end
        S_FIRE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A full mask takes priority over a timeout landing in the same cycle.
          if (all_done) begin
            red_en  <= 1'b1;
            red_sel <= '0;
            state   <= S_REDUCE;
          end else if (tcnt == TO_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_REDUCE: begin
          if (red_sel == LAST_SEL) begin
            red_en    <= 1'b0;
            red_sel   <= '0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            red_sel <= red_sel + 3'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_pass) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              pass_idx <= pass_idx + PASS_W'(1);
              load_req <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_col_sched.sv
// Directed bench for pe_col_sched with a PE/handshake model and scoreboard queues.
module tb_pe_col_sched;
  localparam int NPE = 3;
  localparam int PW  = 8;
  localparam logic [NPE-1:0] EN_ALL = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] num_pass = '0;
  logic          busy, done, err, load_req, red_en, out_valid;
  logic          load_ack = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] pass_idx;
  logic [NPE-1:0] pe_en;
  logic [NPE-1:0] pe_done = '0;
  logic [2:0]    red_sel;

  pe_col_sched #(.NUM_PE(NPE), .PASS_W(PW), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .num_pass(num_pass),
    .busy(busy), .done(done), .err(err), .load_req(load_req),
    .load_ack(load_ack), .pass_idx(pass_idx), .pe_en(pe_en),
    .pe_done(pe_done), .red_sel(red_sel), .red_en(red_en),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, s_cyc = 0;
  int en_cyc = -100000;
  int dly[NPE];
  bit fire_pulse = 0;
  int ack_dly = 0, rdy_dly = 0, req_cnt = 0, vcnt = 0;

  int n_done, done_cyc, acc_cyc, ov_cnt, busy_cnt, n_load, lr_clash, red_first;
  int en_hist[$];
  int exp_pass[$];
  int exp_sel[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, busy, done, err, load_req, out_valid, red_en, pe_en, red_sel, pass_idx};
  endfunction

  // PE and handshake partner model, driven just after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pe_en != '0) en_cyc = cyc;
    pe_done = '0;
    if (pe_en != '0 && fire_pulse) pe_done = '1;
    for (int b = 0; b < NPE; b++)
      if (cyc == en_cyc + dly[b]) pe_done[b] = 1'b1;
    req_cnt   = load_req ? req_cnt + 1 : 0;
    load_ack  = load_req && (req_cnt > ack_dly);
    vcnt      = out_valid ? vcnt + 1 : 0;
    out_ready = out_valid && (vcnt > rdy_dly);
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (red_en) begin
        if (red_first < 0) red_first = cyc;
        if (exp_sel.size() == 0) check("red_unexpected", 32'd1, 32'd0);
        else check("red_sel", 32'(red_sel), 32'(exp_sel.pop_front()));
      end else begin
        check("red_sel_idle", 32'(red_sel), 32'd0);
      end
      if (pe_en != '0) begin
        check("pe_en_all", 32'(pe_en), 32'(EN_ALL));
        en_hist.push_back(cyc);
      end
      if (out_valid) begin
        ov_cnt++;
        if (load_req) lr_clash++;
        if (out_ready) begin
          acc_cyc = cyc;
          if (exp_pass.size() == 0) check("out_unexpected", 32'd1, 32'd0);
          else check("pass_idx_out", 32'(pass_idx), 32'(exp_pass.pop_front()));
        end
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (load_req) n_load++;
    end
  end

  task automatic clr_stats();
    n_done = 0; done_cyc = -1; acc_cyc = -1; ov_cnt = 0; busy_cnt = 0;
    n_load = 0; lr_clash = 0; red_first = -1;
    en_hist.delete();
  endtask

  task automatic push_job(input int n);
    for (int p = 0; p < n; p++) begin
      exp_pass.push_back(p);
      for (int r = 0; r < NPE; r++) exp_sel.push_back(r);
    end
  endtask

  task automatic do_start(input logic [PW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_pass = n; s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0;
    for (int b = 0; b < NPE; b++) dly[b] = 6;
    clr_stats();
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Single pass, ack after 2 cycles
    ack_dly = 2; clr_stats(); push_job(1);
    do_start(8'd1);
    wait_done(200, "single_done");
    check("single_en_cnt", 32'(en_hist.size()), 32'd1);
    check("single_ov_cnt", 32'(ov_cnt), 32'd1);
    check("single_done_lat", 32'(done_cyc - acc_cyc), 32'd1);
    check("single_pass_idx", 32'(pass_idx), 32'd0);
    check("single_sb_empty", 32'(exp_sel.size() + exp_pass.size()), 32'd0);

    // Four passes, everything immediate
    ack_dly = 0; clr_stats(); push_job(4);
    do_start(8'd4);
    wait_done(400, "multi_done");
    check("multi_en_cnt", 32'(en_hist.size()), 32'd4);
    if (en_hist.size() == 4)
      for (int i = 1; i < 4; i++) check("multi_en_space", 32'(en_hist[i] - en_hist[i-1]), 32'd12);
    check("multi_busy_cycles", 32'(busy_cnt), 32'd48);
    check("multi_done_cnt", 32'(n_done), 32'd1);
    check("multi_sb_empty", 32'(exp_sel.size() + exp_pass.size()), 32'd0);

    // Staggered PE done, with a spurious all-ones pulse in the fire cycle
    dly[0] = 4; dly[1] = 6; dly[2] = 9; fire_pulse = 1;
    clr_stats(); push_job(1);
    do_start(8'd1);
    wait_done(200, "stagger_done");
    en0 = (en_hist.size() > 0) ? en_hist[0] : -1000;
    check("stagger_red_start", 32'(red_first - en0), 32'd10);
    fire_pulse = 0;
    for (int b = 0; b < NPE; b++) dly[b] = 6;

    // Backpressure: ready withheld 5 cycles each pass; start pulses while busy
    rdy_dly = 5; clr_stats(); push_job(2);
    do_start(8'd2);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start = ((i % 7) == 3) && busy;
      num_pass = 8'd7;
      @(negedge clk);
      if (done) break;
    end
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_done_cnt", 32'(n_done), 32'd1);
    check("bp_ov_cycles", 32'(ov_cnt), 32'd12);
    check("bp_busy_cycles", 32'(busy_cnt), 32'd34);
    check("bp_load_during_out", 32'(lr_clash), 32'd0);
    check("bp_en_cnt", 32'(en_hist.size()), 32'd2);
    check("bp_idle_after", 32'(busy), 32'd0);
    rdy_dly = 0;

    // Timeout: PE 2 never reports done
    dly[2] = 99999; clr_stats();
    do_start(8'd1);
    wait_done(300, "to_done");
    en0 = (en_hist.size() > 0) ? en_hist[0] : -1000;
    check("to_err", 32'(err), 32'd1);
    check("to_done_lat", 32'(done_cyc - en0), 32'd64);
    check("to_no_out", 32'(ov_cnt), 32'd0);
    check("to_idle", 32'(busy), 32'd0);
    dly[2] = 6; clr_stats(); push_job(1);
    do_start(8'd1);
    check("to_err_cleared", 32'(err), 32'd0);
    wait_done(200, "to_rerun_done");

    // Reset while waiting on the PEs
    for (int b = 0; b < NPE; b++) dly[b] = 99999;
    clr_stats();
    do_start(8'd2);
    repeat (5) @(posedge clk);
    #3; rst = 1'b0;
    #1; check("rst_async_outs", outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    exp_pass.delete(); exp_sel.delete();
    repeat (5) @(negedge clk);
    check("rst_no_done", 32'(n_done), 32'd0);
    check("rst_idle", 32'(busy), 32'd0);
    for (int b = 0; b < NPE; b++) dly[b] = 6;

    // Zero-pass job
    clr_stats();
    do_start(8'd0);
    repeat (4) @(negedge clk);
    check("zero_done_cnt", 32'(n_done), 32'd1);
    check("zero_done_lat", 32'(done_cyc - s_cyc), 32'd1);
    check("zero_busy", 32'(busy_cnt), 32'd0);
    check("zero_load", 32'(n_load), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
